frontend_tx_sw: RTL and testbench

- TX-side counterpart of the RX frontend switch: routes 4 DUC I/Q streams onto 2 DAC frontends.
- Each DAC output is the saturated sum of the enabled DUC channels mapped to it.
- Sits between the DUC chains and the DAC interface; configured over the settings bus.
- Routing changes are deferred until all TX chains are idle, so mid-burst glitches cannot occur.

---
 rtl/frontend_tx_sw.sv | 234 +++++++++++++++++++++++
 tb/tb_frontend_tx_sw.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/frontend_tx_sw.sv
// frontend_tx_sw: routes four DUC I/Q streams onto two DAC frontends.
// Each DAC output is the saturated sum of the enabled channels mapped to it.
// Routing updates wait until every TX chain is idle, so a burst never sees a
// half-applied configuration.
// Optional macro FRONTEND_TX_SW_CLIP_CNT_EN adds per-DAC 16-bit clip counters.
module frontend_tx_sw #(
    parameter int BASE = 0,
    parameter int DW   = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_stb,
    input  logic [7:0]           set_addr,
    input  logic [31:0]          set_data,
    input  logic signed [DW-1:0] i_0_in,
    input  logic signed [DW-1:0] i_1_in,
    input  logic signed [DW-1:0] i_2_in,
    input  logic signed [DW-1:0] i_3_in,
    input  logic signed [DW-1:0] q_0_in,
    input  logic signed [DW-1:0] q_1_in,
    input  logic signed [DW-1:0] q_2_in,
    input  logic signed [DW-1:0] q_3_in,
    input  logic                 run_0_in,
    input  logic                 run_1_in,
    input  logic                 run_2_in,
    input  logic                 run_3_in,
    output logic signed [DW-1:0] i_dac_0,
    output logic signed [DW-1:0] q_dac_0,
    output logic signed [DW-1:0] i_dac_1,
    output logic signed [DW-1:0] q_dac_1,
    output logic                 run_dac_0,
    output logic                 run_dac_1,
    output logic                 clip_0,
    output logic                 clip_1,
    output logic                 cfg_pending,
    output logic [7:0]           active_cfg
`ifdef FRONTEND_TX_SW_CLIP_CNT_EN
    ,
    output logic [15:0]          clip_cnt_0,
    output logic [15:0]          clip_cnt_1
`endif
);

    localparam logic [7:0] ADDR_CFG = 8'(BASE);
    localparam logic [7:0] ADDR_CLR = 8'(BASE + 1);

    // Sign-extend one bit for the pairwise adders.
    function automatic logic signed [DW:0] sext1(input logic signed [DW-1:0] v);
        return {v[DW-1], v};
    endfunction

    // Sign-extend one more bit for the final adder.
    function automatic logic signed [DW+1:0] sext2(input logic signed [DW:0] v);
        return {v[DW], v};
    endfunction

    // Out of range when the top three bits of the wide sum disagree.
    function automatic logic ovf(input logic signed [DW+1:0] v);
        return !((v[DW+1:DW-1] == 3'b000) || (v[DW+1:DW-1] == 3'b111));
    endfunction

    // Clamp the wide sum to the DW-bit signed range.
    function automatic logic signed [DW-1:0] sat(input logic signed [DW+1:0] v);
        if (ovf(v)) return v[DW+1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        return v[DW-1:0];
    endfunction

    logic signed [DW-1:0] i_in [4];
    logic signed [DW-1:0] q_in [4];
    logic [3:0]           run_in;
    logic [7:0]           pending_cfg;
    logic                 cfg_wr;
    logic                 clr_wr;
    logic [3:0]           route;
    logic [3:0]           en;
    logic [1:0][3:0]      map;
    logic                 unused_bits;

    logic signed [DW-1:0] x_i_p0 [2][4];
    logic signed [DW-1:0] x_q_p0 [2][4];
    logic [1:0]           run_p0;
    logic signed [DW:0]   p_i_p1 [2][2];
    logic signed [DW:0]   p_q_p1 [2][2];
    logic [1:0]           run_p1;
    logic signed [DW+1:0] sum_i [2];
    logic signed [DW+1:0] sum_q [2];
    logic [1:0]           clip_now;
    logic signed [DW-1:0] dac_i_p2 [2];
    logic signed [DW-1:0] dac_q_p2 [2];
    logic [1:0]           run_p2;
    logic [1:0]           clip;

    assign i_in[0] = i_0_in;
    assign i_in[1] = i_1_in;
    assign i_in[2] = i_2_in;
    assign i_in[3] = i_3_in;
    assign q_in[0] = q_0_in;
    assign q_in[1] = q_1_in;
    assign q_in[2] = q_2_in;
    assign q_in[3] = q_3_in;
    assign run_in  = {run_3_in, run_2_in, run_1_in, run_0_in};

    assign cfg_wr      = set_stb && (set_addr == ADDR_CFG);
    assign clr_wr      = set_stb && (set_addr == ADDR_CLR);
    assign unused_bits = ^set_data[31:8];
    assign route       = active_cfg[3:0];
    assign en          = active_cfg[7:4];
    assign map         = {en & run_in & route, en & run_in & ~route};

    // Config registers: latch writes, apply only when no write and all chains idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_cfg <= '0;
            cfg_pending <= 1'b0;
            active_cfg  <= '0;
        end else if (cfg_wr) begin
            pending_cfg <= set_data[7:0];
            cfg_pending <= 1'b1;
        end else if (cfg_pending && (run_in == 4'b0000)) begin
            active_cfg  <= pending_cfg;
            cfg_pending <= 1'b0;
        end
    end

    // S1: gate each channel onto the DAC it is mapped to, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    x_i_p0[d][k] <= '0;
                    x_q_p0[d][k] <= '0;
                end
            end
            run_p0 <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    x_i_p0[d][k] <= map[d][k] ? i_in[k] : '0;
                    x_q_p0[d][k] <= map[d][k] ? q_in[k] : '0;
                end
            end
            run_p0 <= {|map[1], |map[0]};
        end
    end

    // S2: pairwise sums at DW+1 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int j = 0; j < 2; j++) begin
                    p_i_p1[d][j] <= '0;
                    p_q_p1[d][j] <= '0;
                end
            end
            run_p1 <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int j = 0; j < 2; j++) begin
                    p_i_p1[d][j] <= sext1(x_i_p0[d][2*j]) + sext1(x_i_p0[d][2*j+1]);
                    p_q_p1[d][j] <= sext1(x_q_p0[d][2*j]) + sext1(x_q_p0[d][2*j+1]);
                end
            end
            run_p1 <= run_p0;
        end
    end

    // S3 combinational part: full-width sum and overflow detect per DAC.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            sum_i[d]    = sext2(p_i_p1[d][0]) + sext2(p_i_p1[d][1]);
            sum_q[d]    = sext2(p_q_p1[d][0]) + sext2(p_q_p1[d][1]);
            clip_now[d] = ovf(sum_i[d]) || ovf(sum_q[d]);
        end
    end

    // S3: saturated DAC samples and aligned run flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                dac_i_p2[d] <= '0;
                dac_q_p2[d] <= '0;
            end
            run_p2 <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                dac_i_p2[d] <= sat(sum_i[d]);
                dac_q_p2[d] <= sat(sum_q[d]);
            end
            run_p2 <= run_p1;
        end
    end

    // Sticky clip flags; a clip in the clear cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (clip_now[d]) clip[d] <= 1'b1;
                else if (clr_wr) clip[d] <= 1'b0;
            end
        end
    end

`ifdef FRONTEND_TX_SW_CLIP_CNT_EN
    logic [15:0] clip_cnt [2];

    // Per-DAC saturating count of clipped output cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt[0] <= '0;
            clip_cnt[1] <= '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (clr_wr) clip_cnt[d] <= clip_now[d] ? 16'd1 : 16'd0;
                else if (clip_now[d] && (clip_cnt[d] != 16'hFFFF)) clip_cnt[d] <= clip_cnt[d] + 16'd1;
            end
        end
    end

    assign clip_cnt_0 = clip_cnt[0];
    assign clip_cnt_1 = clip_cnt[1];
`endif

    assign i_dac_0   = dac_i_p2[0];
    assign q_dac_0   = dac_q_p2[0];
    assign i_dac_1   = dac_i_p2[1];
    assign q_dac_1   = dac_q_p2[1];
    assign run_dac_0 = run_p2[0];
    assign run_dac_1 = run_p2[1];
    assign clip_0    = clip[0];
    assign clip_1    = clip[1];

endmodule

// File: tb/tb_frontend_tx_sw.sv
// Directed bench for frontend_tx_sw (DW=24, BASE=16).
module tb_frontend_tx_sw;

    localparam int BASE = 16;
    localparam int DW   = 24;
    localparam logic [7:0] A_CFG = 8'd16;
    localparam logic [7:0] A_CLR = 8'd17;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 set_stb = 1'b0;
    logic [7:0]           set_addr = '0;
    logic [31:0]          set_data = '0;
    logic signed [DW-1:0] i_in [4];
    logic signed [DW-1:0] q_in [4];
    logic [3:0]           run = '0;
    logic signed [DW-1:0] i_dac_0, q_dac_0, i_dac_1, q_dac_1;
    logic                 run_dac_0, run_dac_1, clip_0, clip_1, cfg_pending;
    logic [7:0]           active_cfg;
`ifdef FRONTEND_TX_SW_CLIP_CNT_EN
    logic [15:0]          clip_cnt_0, clip_cnt_1;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    frontend_tx_sw #(.BASE(BASE), .DW(DW)) dut (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_0_in(i_in[0]), .i_1_in(i_in[1]), .i_2_in(i_in[2]), .i_3_in(i_in[3]),
        .q_0_in(q_in[0]), .q_1_in(q_in[1]), .q_2_in(q_in[2]), .q_3_in(q_in[3]),
        .run_0_in(run[0]), .run_1_in(run[1]), .run_2_in(run[2]), .run_3_in(run[3]),
        .i_dac_0(i_dac_0), .q_dac_0(q_dac_0), .i_dac_1(i_dac_1), .q_dac_1(q_dac_1),
        .run_dac_0(run_dac_0), .run_dac_1(run_dac_1), .clip_0(clip_0), .clip_1(clip_1),
        .cfg_pending(cfg_pending), .active_cfg(active_cfg)
`ifdef FRONTEND_TX_SW_CLIP_CNT_EN
        , .clip_cnt_0(clip_cnt_0), .clip_cnt_1(clip_cnt_1)
`endif
    );

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%06h, expected 0x%06h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic drive(input logic [23:0] iv, input logic [23:0] qv, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            i_in[k] = iv;
            q_in[k] = qv;
        end
        run = r;
    endtask

    initial begin
        drive(24'd0, 24'd0, 4'b0000);
        ticks(2);
        rst = 1'b0;
        check("rst_i_dac_0", i_dac_0, 24'd0);
        check("rst_run_dac_1", {23'd0, run_dac_1}, 24'd0);
        check("rst_clip_0", {23'd0, clip_0}, 24'd0);
        check("rst_cfg_pending", {23'd0, cfg_pending}, 24'd0);
        check("rst_active_cfg", {16'd0, active_cfg}, 24'd0);

        // Config 0xF2: ch1 to DAC1, others to DAC0, all enabled.
        wr(A_CFG, 32'hABCD_00F2);
        check("f2_pending", {23'd0, cfg_pending}, 24'd1);
        check("f2_active_old", {16'd0, active_cfg}, 24'd0);
        tick();
        check("f2_applied_pend", {23'd0, cfg_pending}, 24'd0);
        check("f2_active", {16'd0, active_cfg}, 24'hF2);

        i_in[1] = 24'd100; q_in[1] = 24'hFFFFFB; run[1] = 1'b1;
        ticks(2);
        check("lat_i_dac_1_early", i_dac_1, 24'd0);
        check("lat_run_dac_1_early", {23'd0, run_dac_1}, 24'd0);
        tick();
        check("route_i_dac_1", i_dac_1, 24'd100);
        check("route_q_dac_1", q_dac_1, 24'hFFFFFB);
        check("route_i_dac_0", i_dac_0, 24'd0);
        check("route_run_dac_1", {23'd0, run_dac_1}, 24'd1);
        check("route_run_dac_0", {23'd0, run_dac_0}, 24'd0);
        drive(24'd0, 24'd0, 4'b0000);
        ticks(3);
        check("drain_run_dac_1", {23'd0, run_dac_1}, 24'd0);

        // Config 0xF0: everything summed into DAC0; positive and negative saturation.
        wr(A_CFG, 32'h0000_00F0);
        tick();
        check("f0_active", {16'd0, active_cfg}, 24'hF0);
        drive(24'h3FFFFF, 24'h800000, 4'b1111);
        ticks(2);
        check("clip_0_early", {23'd0, clip_0}, 24'd0);
        tick();
        check("sat_pos_i_dac_0", i_dac_0, 24'h7FFFFF);
        check("sat_neg_q_dac_0", q_dac_0, 24'h800000);
        check("sat_clip_0", {23'd0, clip_0}, 24'd1);
        check("sat_clip_1", {23'd0, clip_1}, 24'd0);
        ticks(4);
`ifdef FRONTEND_TX_SW_CLIP_CNT_EN
        check("clip_cnt_0_five", {8'd0, clip_cnt_0}, 24'd5);
        check("clip_cnt_1_zero", {8'd0, clip_cnt_1}, 24'd0);
`endif
        wr(A_CLR, 32'd0);
        check("clr_vs_clip_0", {23'd0, clip_0}, 24'd1);
`ifdef FRONTEND_TX_SW_CLIP_CNT_EN
        check("clr_vs_cnt_0", {8'd0, clip_cnt_0}, 24'd1);
`endif
        drive(24'd0, 24'd0, 4'b0000);
        ticks(3);
        check("idle_i_dac_0", i_dac_0, 24'd0);
        check("sticky_clip_0", {23'd0, clip_0}, 24'd1);
        wr(A_CLR, 32'hFFFF_FFFF);
        check("clr_clip_0", {23'd0, clip_0}, 24'd0);
`ifdef FRONTEND_TX_SW_CLIP_CNT_EN
        check("clr_cnt_0", {8'd0, clip_cnt_0}, 24'd0);
`endif
        drive(24'h3FFFFF, 24'd0, 4'b1111);
        ticks(3);
        check("reclip_clip_0", {23'd0, clip_0}, 24'd1);
        drive(24'd0, 24'd0, 4'b0000);
        ticks(3);
        wr(A_CLR, 32'd0);
        check("reclr_clip_0", {23'd0, clip_0}, 24'd0);

        // Wide intermediate: pairs overflow DW bits but the total is -2.
        i_in[0] = 24'h7FFFFF; i_in[1] = 24'h7FFFFF; i_in[2] = 24'h800000; i_in[3] = 24'h800000;
        q_in[0] = 24'h800000; q_in[1] = 24'h800000; q_in[2] = 24'h7FFFFF; q_in[3] = 24'h7FFFFF;
        run = 4'b1111;
        ticks(3);
        check("wide_i_dac_0", i_dac_0, 24'hFFFFFE);
        check("wide_q_dac_0", q_dac_0, 24'hFFFFFE);
        check("wide_no_clip", {23'd0, clip_0}, 24'd0);
        drive(24'd0, 24'd0, 4'b0000);
        ticks(3);

        // Apply deferred while a chain runs.
        run[0] = 1'b1; i_in[0] = 24'd7; i_in[1] = 24'd50; run[1] = 1'b1;
        wr(A_CFG, 32'h0000_0011);
        ticks(2);
        check("busy_pending", {23'd0, cfg_pending}, 24'd1);
        check("busy_active", {16'd0, active_cfg}, 24'hF0);
        run = 4'b0000;
        tick();
        check("idle_apply_active", {16'd0, active_cfg}, 24'h11);
        check("idle_apply_pend", {23'd0, cfg_pending}, 24'd0);
        run[0] = 1'b1; run[1] = 1'b1;
        ticks(3);
        check("c11_i_dac_1", i_dac_1, 24'd7);
        check("c11_i_dac_0", i_dac_0, 24'd0);
        check("c11_run_dac_0", {23'd0, run_dac_0}, 24'd0);
        check("c11_run_dac_1", {23'd0, run_dac_1}, 24'd1);
        drive(24'd0, 24'd0, 4'b0000);
        ticks(3);

        // Back-to-back writes: last one wins, first is never applied.
        set_stb = 1'b1; set_addr = A_CFG; set_data = 32'h10;
        tick();
        check("b2b_active_1", {16'd0, active_cfg}, 24'h11);
        set_data = 32'h20;
        tick();
        set_stb = 1'b0;
        check("b2b_active_2", {16'd0, active_cfg}, 24'h11);
        check("b2b_pending", {23'd0, cfg_pending}, 24'd1);
        tick();
        check("b2b_active_final", {16'd0, active_cfg}, 24'h20);

        // Other addresses have no effect.
        wr(8'd18, 32'hFF);
        check("other_addr_pend", {23'd0, cfg_pending}, 24'd0);
        check("other_addr_active", {16'd0, active_cfg}, 24'h20);

        // Reset mid-stream.
        i_in[1] = 24'd9; run[1] = 1'b1;
        ticks(3);
        check("pre_rst_i_dac_0", i_dac_0, 24'd9);
        rst = 1'b1;
        tick();
        check("mid_rst_i_dac_0", i_dac_0, 24'd0);
        check("mid_rst_run_dac_0", {23'd0, run_dac_0}, 24'd0);
        check("mid_rst_active", {16'd0, active_cfg}, 24'd0);
        rst = 1'b0;
        drive(24'd0, 24'd0, 4'b0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
